mips_multicycle_core: RTL and testbench

Multicycle successor to the single-cycle MIPS processor. Executes a MIPS-I integer subset over a shared instruction/data bus with a ready handshake, so one memory serves both fetch and load/store, and wait states are tolerated. Adds jumps, `jal`/`jr`, memory-mapped I/O ports, and an illegal-opcode halt. Sits at the top of the CPU, replacing the single-cycle datapath; external memory and peripherals attach to its bus and port pins.

---
 rtl/mips_multicycle_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-I integer core. A single shared bus serves both instruction
// fetch and load/store. Loads and stores that hit the two-word I/O window go to
// the on-chip PortIn/PortOut registers and never reach the bus.
//
// Bus handshake: mem_req is raised in FETCH, and in MEM for non-I/O addresses.
// While mem_req=1 the values of mem_addr, mem_we and mem_wdata stay constant.
// The transfer completes on the rising edge where mem_ready=1. mem_ready may
// already be 1 in the first request cycle. mem_rdata is only looked at in that
// completing cycle.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] PORT_BASE = 32'h1001_0024,
  parameter int          IN_WIDTH  = 8,
  parameter int          OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic [31:0]          ALUResultOut,
  output logic [OUT_WIDTH-1:0] PortOut,
  output logic                 halted,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  state_t state, state_next;

  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  // Instruction fields, always taken from IR
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext_imm, zext_imm;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign target   = ir[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};

  logic is_r, is_lw, is_sw, is_branch, is_jump, is_jal, is_jr, legal, take;

  assign is_r      = (op == OP_R);
  assign is_lw     = (op == OP_LW);
  assign is_sw     = (op == OP_SW);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jump   = (op == OP_J) || (op == OP_JAL);
  assign is_jal    = (op == OP_JAL);
  assign is_jr     = is_r && (funct == FN_JR);
  assign take      = (op == OP_BEQ) ? (a == b) : (a != b);

  // Decide whether IR holds a supported opcode/funct pair
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // ALU: computes the result, the effective address, or A-B for branches
  logic [31:0] alu_result;
  always_comb begin
    alu_result = a + sext_imm;
    case (op)
      OP_R: begin
        case (funct)
          FN_SLL:          alu_result = b << shamt;
          FN_SRL:          alu_result = b >> shamt;
          FN_SUB, FN_SUBU: alu_result = a - b;
          FN_AND:          alu_result = a & b;
          FN_OR:           alu_result = a | b;
          FN_NOR:          alu_result = ~(a | b);
          FN_SLT:          alu_result = {31'd0, $signed(a) < $signed(b)};
          FN_SLTU:         alu_result = {31'd0, a < b};
          default:         alu_result = a + b;
        endcase
      end
      OP_ANDI:        alu_result = a & zext_imm;
      OP_ORI:         alu_result = a | zext_imm;
      OP_LUI:         alu_result = {imm, 16'h0000};
      OP_SLTI:        alu_result = {31'd0, $signed(a) < $signed(sext_imm)};
      OP_BEQ, OP_BNE: alu_result = a - b;
      default:        alu_result = a + sext_imm;
    endcase
  end

  // I/O window decode on the word-aligned data address held in ALUOut
  logic [31:0] data_addr, port_in_ext, port_out_ext;
  logic        io_in, io_out, is_io;

  assign data_addr = {alu_out[31:2], 2'b00};
  assign io_in     = (data_addr == PORT_BASE);
  assign io_out    = (data_addr == PORT_BASE + 32'd4);
  assign is_io     = io_in || io_out;

  // Zero-extend PortIn to a full word for loads
  always_comb begin
    port_in_ext = '0;
    port_in_ext[IN_WIDTH-1:0] = PortIn;
  end

  // Zero-extend PortOut to a full word for loads
  always_comb begin
    port_out_ext = '0;
    port_out_ext[OUT_WIDTH-1:0] = PortOut;
  end

  // State register; reset wins from any state, including mid-request
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic and bus outputs. Reset gates off the request immediately
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {pc[31:2], 2'b00};
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_branch || is_jump || is_jr) state_next = S_FETCH;
        else if (is_lw || is_sw)           state_next = S_MEM;
        else                               state_next = S_WB;
      end
      S_MEM: begin
        mem_addr = data_addr;
        if (is_io) begin
          state_next = is_sw ? S_FETCH : S_WB;
        end else begin
          mem_req = 1'b1;
          mem_we  = is_sw;
          if (mem_ready) state_next = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign mem_wdata = b;
  assign halted    = (state == S_HALT);
  assign dbg_state = state;

  // Datapath registers: PC, IR, A, B, ALUOut, MDR and the two visible outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      ALUResultOut <= '0;
      PortOut      <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc + {sext_imm[29:0], 2'b00};
        end
        S_EXEC: begin
          ALUResultOut <= alu_result;
          if (is_branch) begin
            if (take) pc <= alu_out;
          end else if (is_jump) begin
            pc <= {pc[31:28], target, 2'b00};
          end else if (is_jr) begin
            pc <= a;
          end else begin
            alu_out <= alu_result;
          end
        end
        S_MEM: begin
          if (is_io) begin
            if (is_lw)       mdr <= io_in ? port_in_ext : port_out_ext;
            else if (io_out) PortOut <= b[OUT_WIDTH-1:0];
          end else if (mem_ready && is_lw) begin
            mdr <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file write port: jal links in EXEC, everything else writes in WB
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    if (state == S_EXEC && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc;
    end else if (state == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = is_r ? rd : rt;
      rf_wdata = is_lw ? mdr : alu_out;
    end
  end

  // Register file storage; writes to $0 are dropped so it always reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a table of short programs, each of
// which stores its result to 0x100 and then halts, plus hand-written sequences
// for wait states, the I/O ports, jal/jr, the halt path and reset.
module tb_mips_multicycle_core;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] PORT_BASE = 32'h1001_0024;
  localparam logic [31:0] HALT_W    = 32'hFC00_0000;
  localparam logic [31:0] RES_ADDR  = 32'h0000_0100;

  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [4:0] ZR = 5'd0, T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11, S0 = 5'd16, RA = 5'd31;

  logic        clk, reset, mem_req, mem_we, mem_ready, halted;
  logic [7:0]  port_in;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, alu_result_out, port_out;
  logic [2:0]  dbg_state;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset), .PortIn(port_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ALUResultOut(alu_result_out), .PortOut(port_out), .halted(halted),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and bus monitor state
  logic [31:0] mem [int unsigned];
  int wait_n, wait_cnt, unstable, port_req, halt_req;
  logic        in_req, req_we;
  logic [31:0] req_a, req_d;

  // Scoreboard counters
  int n_vec, n_fail;
  logic [31:0] exp_q[$];

  typedef struct {
    string           name;
    logic [3:0][31:0] prog;
    int              n;
    logic [4:0]      rres;
    logic [31:0]     exp_val;
    int              exp_cyc;
  } vec_t;
  vec_t vecs[19];

  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] jj(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: one clock cycle. The memory is serviced on the falling edge, when
  // the core's bus outputs are settled; the bench samples #1 after the rising edge.
  task automatic step();
    @(negedge clk);
    if (mem_req) begin
      if (in_req && (mem_addr !== req_a || mem_we !== req_we || mem_wdata !== req_d))
        unstable++;
      if (mem_addr == PORT_BASE || mem_addr == PORT_BASE + 32'd4) port_req++;
      if (halted) halt_req++;
      if (wait_cnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = rd_mem(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        wait_cnt  = 0;
        in_req    = 1'b0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt++;
        in_req    = 1'b1;
      end
      req_a  = mem_addr;
      req_we = mem_we;
      req_d  = mem_wdata;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      wait_cnt  = 0;
      in_req    = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem[a] = d;
  endtask

  // Reset, release, and run until halted or the cycle budget runs out.
  // cyc counts rising edges after release; mark_* record the first cycle a
  // fetch of the given address is seen on the bus.
  task automatic run_prog(input int budget, input logic [31:0] mark_a, input logic [31:0] mark_b,
                          output int cyc, output int cyc_a, output int cyc_b);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
    cyc_a = -1;
    cyc_b = -1;
    while (cyc < budget) begin
      step();
      cyc++;
      if (mem_req && mem_addr == mark_a && cyc_a < 0) cyc_a = cyc;
      if (mem_req && mem_addr == mark_b && cyc_b < 0) cyc_b = cyc;
      if (halted) break;
    end
  endtask

  task automatic set_vec(input int idx, input string name, input logic [4:0] rres, input int n,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] exp_val, input int exp_cyc);
    vecs[idx].name    = name;
    vecs[idx].prog    = {w3, w2, w1, w0};
    vecs[idx].n       = n;
    vecs[idx].rres    = rres;
    vecs[idx].exp_val = exp_val;
    vecs[idx].exp_cyc = exp_cyc;
  endtask

  initial begin
    int cyc, ca, cb;
    logic [31:0] exp_v;
    n_vec = 0; n_fail = 0;
    reset = 1'b1; port_in = 8'hA5; mem_ready = 1'b0; mem_rdata = 32'h0;
    wait_n = 0; wait_cnt = 0; unstable = 0; port_req = 0; halt_req = 0;
    in_req = 1'b0; req_we = 1'b0; req_a = 32'h0; req_d = 32'h0;

    // Vector table. Cycle budget: ALU 4, lw 5, sw 4, branch/jump 3, plus the
    // result store (4) and the halt word's fetch+decode (2).
    set_vec(0,  "addi_neg", T1, 2, ii(OP_ADDI, ZR, T0, 16'h0005), ii(OP_ADDI, T0, T1, 16'hFFF9), 0, 0, 32'hFFFF_FFFE, 14);
    set_vec(1,  "lui_ori",  T0, 2, ii(OP_LUI, ZR, T0, 16'h1234), ii(OP_ORI, T0, T0, 16'h5678), 0, 0, 32'h1234_5678, 14);
    set_vec(2,  "srl",      T1, 2, ii(OP_ADDI, ZR, T0, 16'hFFFF), rr(ZR, T0, T1, 5'd4, 6'h02), 0, 0, 32'h0FFF_FFFF, 14);
    set_vec(3,  "sll",      T1, 2, ii(OP_ADDI, ZR, T0, 16'h0003), rr(ZR, T0, T1, 5'd31, 6'h00), 0, 0, 32'h8000_0000, 14);
    set_vec(4,  "slt",      T2, 3, ii(OP_ADDI, ZR, T0, 16'hFFFF), ii(OP_ADDI, ZR, T1, 16'h0001), rr(T0, T1, T2, 5'd0, 6'h2A), 0, 32'h1, 18);
    set_vec(5,  "sltu",     T2, 3, ii(OP_ADDI, ZR, T0, 16'hFFFF), ii(OP_ADDI, ZR, T1, 16'h0001), rr(T0, T1, T2, 5'd0, 6'h2B), 0, 32'h0, 18);
    set_vec(6,  "nor",      T2, 3, ii(OP_ADDI, ZR, T0, 16'h0F0F), ii(OP_ADDI, ZR, T1, 16'h00FF), rr(T0, T1, T2, 5'd0, 6'h27), 0, 32'hFFFF_F000, 18);
    set_vec(7,  "sub",      T2, 3, ii(OP_ADDI, ZR, T0, 16'h0F0F), ii(OP_ADDI, ZR, T1, 16'h00FF), rr(T0, T1, T2, 5'd0, 6'h22), 0, 32'h0000_0E10, 18);
    set_vec(8,  "and",      T2, 3, ii(OP_ADDI, ZR, T0, 16'h0F0F), ii(OP_ADDI, ZR, T1, 16'h00FF), rr(T0, T1, T2, 5'd0, 6'h24), 0, 32'h0000_000F, 18);
    set_vec(9,  "or",       T2, 3, ii(OP_ADDI, ZR, T0, 16'h0F0F), ii(OP_ADDI, ZR, T1, 16'h00FF), rr(T0, T1, T2, 5'd0, 6'h25), 0, 32'h0000_0FFF, 18);
    set_vec(10, "andi_zx",  T1, 2, ii(OP_ADDI, ZR, T0, 16'hFFFF), ii(OP_ANDI, T0, T1, 16'h8001), 0, 0, 32'h0000_8001, 14);
    set_vec(11, "slti",     T1, 2, ii(OP_ADDI, ZR, T0, 16'hFFFD), ii(OP_SLTI, T0, T1, 16'hFFFE), 0, 0, 32'h1, 14);
    set_vec(12, "addu",     T1, 2, ii(OP_ADDIU, ZR, T0, 16'h7FFF), rr(T0, T0, T1, 5'd0, 6'h21), 0, 0, 32'h0000_FFFE, 14);
    set_vec(13, "wr_zero",  ZR, 1, ii(OP_ADDI, ZR, ZR, 16'h0009), 0, 0, 0, 32'h0, 10);
    set_vec(14, "sw_lw",    T1, 3, ii(OP_ADDI, ZR, T0, 16'h0055), ii(OP_SW, ZR, T0, 16'h0040), ii(OP_LW, ZR, T1, 16'h0040), 0, 32'h55, 19);
    set_vec(15, "bne_nt",   T2, 4, ii(OP_ADDI, ZR, T0, 16'h0001), ii(OP_ADDI, ZR, T1, 16'h0001), ii(OP_BNE, T0, T1, 16'h0001), ii(OP_ADDI, ZR, T2, 16'h0007), 32'h7, 21);
    set_vec(16, "bne_tk",   T1, 4, ii(OP_ADDI, ZR, T1, 16'h0003), ii(OP_ADDI, ZR, T0, 16'h0001), ii(OP_BNE, T0, ZR, 16'h0001), ii(OP_ADDI, ZR, T1, 16'h0007), 32'h3, 17);
    set_vec(17, "beq_loop", T0, 3, ii(OP_ADDI, ZR, T1, 16'h0001), ii(OP_ADDI, T0, T0, 16'h0001), ii(OP_BEQ, T0, T1, 16'hFFFE), 0, 32'h2, 24);
    set_vec(18, "j_skip",   T1, 3, ii(OP_ADDI, ZR, T1, 16'h0004), jj(OP_J, 26'h010_0003), ii(OP_ADDI, ZR, T1, 16'h0009), 0, 32'h4, 13);

    // Sequence: addi chain with exact ALUResultOut timing
    mem.delete();
    put(RESET_PC,      ii(OP_ADDI, ZR, T0, 16'h0005));
    put(RESET_PC + 4,  ii(OP_ADDI, T0, T1, 16'hFFF9));
    put(RESET_PC + 8,  HALT_W);
    step(); step();
    reset = 1'b0;
    #1;
    check32("fetch_addr_after_reset", mem_addr, RESET_PC);
    check32("fetch_req_after_reset", {31'd0, mem_req}, 32'h1);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 6) check32("alu_out_cycle7", alu_result_out, 32'h0000_0005);
      if (c == 7) check32("alu_out_cycle8", alu_result_out, 32'hFFFF_FFFE);
    end

    // Table-driven vectors with zero-wait memory
    for (int v = 0; v < 19; v++) begin
      mem.delete();
      for (int k = 0; k < vecs[v].n; k++) put(RESET_PC + 32'(4 * k), vecs[v].prog[k]);
      put(RESET_PC + 32'(4 * vecs[v].n),     ii(OP_SW, ZR, vecs[v].rres, 16'h0100));
      put(RESET_PC + 32'(4 * vecs[v].n + 4), HALT_W);
      exp_q.push_back(vecs[v].exp_val);
      run_prog(200, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, ca, cb);
      exp_v = exp_q.pop_front();
      check32({vecs[v].name, "_val"}, rd_mem(RES_ADDR), exp_v);
      check_int({vecs[v].name, "_cyc"}, cyc, vecs[v].exp_cyc);
    end

    // Sequence: sw then lw through the bus with two wait states per request
    mem.delete();
    wait_n = 2; unstable = 0;
    put(RESET_PC,      ii(OP_LUI, ZR, T0, 16'h1234));
    put(RESET_PC + 4,  ii(OP_ORI, T0, T0, 16'h5678));
    put(RESET_PC + 8,  ii(OP_LUI, ZR, S0, 16'h1001));
    put(RESET_PC + 12, ii(OP_SW, S0, T0, 16'h0000));
    put(RESET_PC + 16, ii(OP_LW, S0, T1, 16'h0000));
    put(RESET_PC + 20, ii(OP_SW, ZR, T1, 16'h0100));
    put(RESET_PC + 24, HALT_W);
    run_prog(300, RESET_PC + 12, RESET_PC + 20, cyc, ca, cb);
    check32("wait_sw_mem", rd_mem(32'h1001_0000), 32'h1234_5678);
    check32("wait_lw_val", rd_mem(RES_ADDR), 32'h1234_5678);
    check_int("wait_sw_lw_cycles", cb - ca, 17);
    check_int("wait_total_cycles", cyc, 47);
    check_int("wait_bus_stable", unstable, 0);
    wait_n = 0;

    // Sequence: I/O window loads and stores
    mem.delete();
    port_req = 0;
    put(RESET_PC,      ii(OP_LUI, ZR, S0, 16'h1001));
    put(RESET_PC + 4,  ii(OP_LW, S0, T2, 16'h0024));
    put(RESET_PC + 8,  ii(OP_SW, S0, T2, 16'h0028));
    put(RESET_PC + 12, ii(OP_SW, S0, S0, 16'h0024));
    put(RESET_PC + 16, ii(OP_LW, S0, T3, 16'h0028));
    put(RESET_PC + 20, ii(OP_SW, ZR, T3, 16'h0100));
    put(RESET_PC + 24, HALT_W);
    run_prog(200, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, ca, cb);
    check32("port_out", port_out, 32'h0000_00A5);
    check32("port_readback", rd_mem(RES_ADDR), 32'h0000_00A5);
    check_int("port_no_bus_req", port_req, 0);
    check_int("port_cycles", cyc, 28);

    // Sequence: reset clears visible state left by the previous program
    reset = 1'b1;
    step();
    check32("rst_mem_req", {31'd0, mem_req}, 32'h0);
    check32("rst_halted", {31'd0, halted}, 32'h0);
    check32("rst_port_out", port_out, 32'h0);
    check32("rst_alu_out", alu_result_out, 32'h0);
    check32("rst_state", {29'd0, dbg_state}, 32'h0);

    // Sequence: jal to a far routine, jr back, store the link register
    mem.delete();
    put(RESET_PC,             jj(OP_JAL, 26'h010_0040));
    put(RESET_PC + 4,         ii(OP_SW, ZR, RA, 16'h0100));
    put(RESET_PC + 8,         HALT_W);
    put(32'h0040_0100,        rr(RA, ZR, ZR, 5'd0, 6'h08));
    run_prog(200, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, ca, cb);
    check32("jal_link", rd_mem(RES_ADDR), RESET_PC + 32'd4);
    check_int("jal_jr_cycles", cyc, 12);

    // Sequence: illegal opcode halts at the DECODE edge and stays off the bus
    mem.delete();
    halt_req = 0;
    put(RESET_PC, HALT_W);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check32("halt_not_yet", {31'd0, halted}, 32'h0);
    step();
    check32("halt_after_decode", {31'd0, halted}, 32'h1);
    repeat (10) step();
    check32("halt_sticky", {31'd0, halted}, 32'h1);
    check_int("halt_no_req", halt_req, 0);
    reset = 1'b1;
    step();
    check32("halt_cleared", {31'd0, halted}, 32'h0);
    reset = 1'b0;
    #1;
    check32("refetch_addr", mem_addr, RESET_PC);
    check32("refetch_req", {31'd0, mem_req}, 32'h1);

    // Sequence: reset while a fetch is stalled in wait states
    wait_n = 5;
    step(); step();
    check32("stall_req_held", {31'd0, mem_req}, 32'h1);
    reset = 1'b1;
    step();
    check32("stall_req_dropped", {31'd0, mem_req}, 32'h0);
    check32("stall_state", {29'd0, dbg_state}, 32'h0);
    reset = 1'b0;
    wait_n = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
